// File: rtl/shiftreg_pkg.sv
// Shared state type and elaboration-time geometry helpers for the shiftreg_deser_valrdy deserializer.
package shiftreg_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   function automatic int beats_of(input int bitwidth, input int lane_w);
      return (lane_w > 32'sd0) ? (bitwidth / lane_w) : 32'sd0;
   endfunction

   // COUNT must be able to hold BEATS itself, hence beats+1 codes.
   function automatic int count_width(input int beats);
      return (beats < 32'sd1) ? 32'sd1 : $clog2(beats + 32'sd1);
   endfunction

   function automatic bit geometry_ok(input int bitwidth, input int lane_w);
      return (lane_w > 32'sd0) && (bitwidth >= lane_w) && ((bitwidth % lane_w) == 32'sd0);
   endfunction

endpackage

// File: rtl/shiftreg_lane_core.sv
// Serial-in/parallel-out lane register with parallel load.
// With SHIFTREG_DESER_FLUSH_EN a variable zero-pad shift aligns a partial word.
module shiftreg_lane_core
   import shiftreg_pkg::*;
#(
   parameter int BITWIDTH  = 32,
   parameter int LANE_W    = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_en,
   input  logic [BITWIDTH-1:0] load_data,
   input  logic                shift_en,
   input  logic [LANE_W-1:0]   shift_in,
`ifdef SHIFTREG_DESER_FLUSH_EN
   input  logic                pad_en,
   input  logic [count_width(beats_of(BITWIDTH, LANE_W))-1:0] pad_lanes,
`endif
   output logic [BITWIDTH-1:0] data
);

   localparam int BEATS = beats_of(BITWIDTH, LANE_W);

   logic [BITWIDTH-1:0] data_r;
   logic [BITWIDTH-1:0] shifted_s;
   logic [BITWIDTH-1:0] next_s;

   generate
      if (BEATS == 32'sd1) begin : g_single
         assign shifted_s = shift_in;
      end else if (MSB_FIRST != 32'sd0) begin : g_msb_first
         assign shifted_s = {data_r[BITWIDTH-LANE_W-1:0], shift_in};
      end else begin : g_lsb_first
         assign shifted_s = {shift_in, data_r[BITWIDTH-1:LANE_W]};
      end
   endgenerate

`ifdef SHIFTREG_DESER_FLUSH_EN
   localparam int SW = $clog2(BITWIDTH + 32'sd1);

   logic [BITWIDTH-1:0] pad_src_s;
   logic [BITWIDTH-1:0] padded_s;
   logic [SW-1:0]       pad_shamt_s;

   // A beat accepted in the flush cycle is folded in before the padding shift.
   assign pad_src_s   = shift_en ? shifted_s : data_r;
   assign pad_shamt_s = SW'(int'(pad_lanes) * LANE_W);

   generate
      if (MSB_FIRST != 32'sd0) begin : g_pad_msb
         assign padded_s = pad_src_s << pad_shamt_s;
      end else begin : g_pad_lsb
         assign padded_s = pad_src_s >> pad_shamt_s;
      end
   endgenerate
`endif

   // Next-value select: load beats flush beats shift.
   always_comb begin
      next_s = data_r;
      if (load_en) begin
         next_s = load_data;
`ifdef SHIFTREG_DESER_FLUSH_EN
      end else if (pad_en) begin
         next_s = padded_s;
`endif
      end else if (shift_en) begin
         next_s = shifted_s;
      end else begin
         next_s = data_r;
      end
   end

   // Lane register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= {BITWIDTH{1'b0}};
      end else begin
         data_r <= next_s;
      end
   end

   assign data = data_r;

endmodule

// File: rtl/shiftreg_deser_valrdy.sv
// Val/rdy deserializer: assembles BITWIDTH/LANE_W input beats into one word on a SIPO register.
// Defining SHIFTREG_DESER_FLUSH_EN adds a FLUSH input that zero-pads and emits a partial word.
module shiftreg_deser_valrdy
   import shiftreg_pkg::*;
#(
   parameter int BITWIDTH  = 32,
   parameter int LANE_W    = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                IN_VAL,
   output logic                IN_RDY,
   input  logic [LANE_W-1:0]   IN_DATA,
   input  logic                LOAD_EN,
   input  logic [BITWIDTH-1:0] LOAD_DATA,
   output logic                OUT_VAL,
   input  logic                OUT_RDY,
   output logic [BITWIDTH-1:0] OUT_DATA,
`ifdef SHIFTREG_DESER_FLUSH_EN
   input  logic                FLUSH,
`endif
   output logic [count_width(beats_of(BITWIDTH, LANE_W))-1:0] COUNT
);

   localparam int             BEATS       = beats_of(BITWIDTH, LANE_W);
   localparam int             CW          = count_width(BEATS);
   localparam logic [CW-1:0]  BEATS_C     = CW'(BEATS);
   localparam bit             SINGLE_BEAT = (BEATS == 32'sd1);

   generate
      if (!geometry_ok(BITWIDTH, LANE_W)) begin : g_bad_geometry
         $fatal(1, "shiftreg_deser_valrdy: BITWIDTH must be a non-zero multiple of LANE_W");
      end
   endgenerate

   state_e        state_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_inc_s;
   logic          out_val_r;
   logic          in_rdy_s;
   logic          in_fire_s;
   logic          out_fire_s;
   logic          last_beat_s;
   logic          flush_go_s;

   // Input ready: a load blocks beats that cycle; a full word only accepts a beat while it drains.
   always_comb begin
      in_rdy_s = 1'b0;
      if (LOAD_EN) begin
         in_rdy_s = 1'b0;
      end else if (state_r == FULL) begin
         in_rdy_s = OUT_RDY;
      end else begin
         in_rdy_s = 1'b1;
      end
   end

   assign in_fire_s   = IN_VAL & in_rdy_s;
   assign out_fire_s  = out_val_r & OUT_RDY;
   assign count_inc_s = count_r + CW'(1'b1);
   assign last_beat_s = in_fire_s && (count_inc_s == BEATS_C);

`ifdef SHIFTREG_DESER_FLUSH_EN
   logic [CW-1:0] pad_lanes_s;

   assign flush_go_s  = FLUSH && (state_r == FILL) && (count_r != {CW{1'b0}}) && !LOAD_EN;
   assign pad_lanes_s = BEATS_C - (in_fire_s ? count_inc_s : count_r);
`else
   assign flush_go_s  = 1'b0;
`endif

   // Word-assembly FSM with beat counter and registered OUT_VAL.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r   <= FILL;
         count_r   <= {CW{1'b0}};
         out_val_r <= 1'b0;
      end else if (LOAD_EN) begin
         state_r   <= FULL;
         count_r   <= BEATS_C;
         out_val_r <= 1'b1;
      end else begin
         case (state_r)
            FILL: begin
               if (in_fire_s) begin
                  count_r <= count_inc_s;
               end else begin
                  count_r <= count_r;
               end
               if (last_beat_s || flush_go_s) begin
                  state_r   <= FULL;
                  out_val_r <= 1'b1;
               end else begin
                  state_r   <= FILL;
                  out_val_r <= 1'b0;
               end
            end
            FULL: begin
               // A beat taken while the word drains starts the next word with no bubble.
               if (out_fire_s && in_fire_s) begin
                  count_r   <= CW'(1'b1);
                  state_r   <= SINGLE_BEAT ? FULL : FILL;
                  out_val_r <= SINGLE_BEAT;
               end else if (out_fire_s) begin
                  count_r   <= {CW{1'b0}};
                  state_r   <= FILL;
                  out_val_r <= 1'b0;
               end else begin
                  count_r   <= count_r;
                  state_r   <= FULL;
                  out_val_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= FILL;
               count_r   <= {CW{1'b0}};
               out_val_r <= 1'b0;
            end
         endcase
      end
   end

   shiftreg_lane_core #(
      .BITWIDTH  (BITWIDTH),
      .LANE_W    (LANE_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .load_en   (LOAD_EN),
      .load_data (LOAD_DATA),
      .shift_en  (in_fire_s),
      .shift_in  (IN_DATA),
`ifdef SHIFTREG_DESER_FLUSH_EN
      .pad_en    (flush_go_s),
      .pad_lanes (pad_lanes_s),
`endif
      .data      (OUT_DATA)
   );

   assign IN_RDY  = in_rdy_s;
   assign OUT_VAL = out_val_r;
   assign COUNT   = count_r;

endmodule

// File: tb/tb_shiftreg_deser_valrdy.sv
// Directed bench for shiftreg_deser_valrdy: 8/1 MSB-first, 32/8 LSB-first and 32/8 MSB-first instances.
// Flush vectors run only when SHIFTREG_DESER_FLUSH_EN is defined.
module tb_shiftreg_deser_valrdy;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   logic        a_in_val, a_in_rdy, a_load_en, a_out_val, a_out_rdy;
   logic [0:0]  a_in_data;
   logic [7:0]  a_load_data, a_out_data;
   logic [3:0]  a_count;

   logic        b_in_val, b_in_rdy, b_load_en, b_out_val, b_out_rdy;
   logic [7:0]  b_in_data;
   logic [31:0] b_load_data, b_out_data;
   logic [2:0]  b_count;

   logic        c_in_val, c_in_rdy, c_load_en, c_out_val, c_out_rdy, c_flush;
   logic [7:0]  c_in_data;
   logic [31:0] c_load_data, c_out_data;
   logic [2:0]  c_count;

   logic [7:0]  pat;
   logic [7:0]  lane_beats [4];

   shiftreg_deser_valrdy #(.BITWIDTH(8), .LANE_W(1), .MSB_FIRST(1)) dut_a (
      .CLK(clk), .RESET_N(rst_n), .IN_VAL(a_in_val), .IN_RDY(a_in_rdy), .IN_DATA(a_in_data),
      .LOAD_EN(a_load_en), .LOAD_DATA(a_load_data), .OUT_VAL(a_out_val), .OUT_RDY(a_out_rdy),
      .OUT_DATA(a_out_data),
`ifdef SHIFTREG_DESER_FLUSH_EN
      .FLUSH(1'b0),
`endif
      .COUNT(a_count));

   shiftreg_deser_valrdy #(.BITWIDTH(32), .LANE_W(8), .MSB_FIRST(0)) dut_b (
      .CLK(clk), .RESET_N(rst_n), .IN_VAL(b_in_val), .IN_RDY(b_in_rdy), .IN_DATA(b_in_data),
      .LOAD_EN(b_load_en), .LOAD_DATA(b_load_data), .OUT_VAL(b_out_val), .OUT_RDY(b_out_rdy),
      .OUT_DATA(b_out_data),
`ifdef SHIFTREG_DESER_FLUSH_EN
      .FLUSH(1'b0),
`endif
      .COUNT(b_count));

   shiftreg_deser_valrdy #(.BITWIDTH(32), .LANE_W(8), .MSB_FIRST(1)) dut_c (
      .CLK(clk), .RESET_N(rst_n), .IN_VAL(c_in_val), .IN_RDY(c_in_rdy), .IN_DATA(c_in_data),
      .LOAD_EN(c_load_en), .LOAD_DATA(c_load_data), .OUT_VAL(c_out_val), .OUT_RDY(c_out_rdy),
      .OUT_DATA(c_out_data),
`ifdef SHIFTREG_DESER_FLUSH_EN
      .FLUSH(c_flush),
`endif
      .COUNT(c_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      a_in_val = 1'b0; a_in_data = 1'b0; a_load_en = 1'b0; a_load_data = 8'h00; a_out_rdy = 1'b0;
      b_in_val = 1'b0; b_in_data = 8'h00; b_load_en = 1'b0; b_load_data = 32'h0; b_out_rdy = 1'b0;
      c_in_val = 1'b0; c_in_data = 8'h00; c_load_en = 1'b0; c_load_data = 32'h0; c_out_rdy = 1'b0;
      c_flush = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_a_data", 32'(a_out_data), 32'h0);
      chk("rst_a_count", 32'(a_count), 32'h0);
      chk("rst_a_val", 32'(a_out_val), 32'h0);
      chk("rst_b_data", b_out_data, 32'h0);
      chk("rst_c_val", 32'(c_out_val), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rdy_a_after_rst", 32'(a_in_rdy), 32'h1);
      chk("rdy_b_after_rst", 32'(b_in_rdy), 32'h1);
      chk("rdy_c_after_rst", 32'(c_in_rdy), 32'h1);

      // Bit-serial, MSB first: 1,0,1,1,0,0,1,0 -> 8'hB2
      a_out_rdy = 1'b1;
      pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         a_in_val  = 1'b1;
         a_in_data = pat[7-i];
         tick();
         if (i == 6) begin
            chk("a_count_7", 32'(a_count), 32'd7);
            chk("a_val_before_last", 32'(a_out_val), 32'h0);
         end
      end
      a_in_val = 1'b0;
      chk("a_val_after_last", 32'(a_out_val), 32'h1);
      chk("a_data_b2", 32'(a_out_data), 32'hB2);
      chk("a_count_full", 32'(a_count), 32'd8);
      tick();
      chk("a_val_consumed", 32'(a_out_val), 32'h0);
      chk("a_count_cleared", 32'(a_count), 32'd0);
      chk("a_data_stale", 32'(a_out_data), 32'hB2);

      // Byte lanes, LSB first, downstream stalled for 5 cycles
      lane_beats[0] = 8'h11; lane_beats[1] = 8'h22; lane_beats[2] = 8'h33; lane_beats[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         b_in_val  = 1'b1;
         b_in_data = lane_beats[i];
         tick();
      end
      b_in_data = 8'h55;
      #1;
      chk("b_val_full", 32'(b_out_val), 32'h1);
      chk("b_data_full", b_out_data, 32'h44332211);
      chk("b_count_full", 32'(b_count), 32'd4);
      chk("b_rdy_stalled", 32'(b_in_rdy), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("b_data_hold", b_out_data, 32'h44332211);
         chk("b_rdy_hold", 32'(b_in_rdy), 32'h0);
         chk("b_val_hold", 32'(b_out_val), 32'h1);
      end
      b_out_rdy = 1'b1;
      b_in_val  = 1'b0;
      #1;
      chk("b_rdy_draining", 32'(b_in_rdy), 32'h1);
      tick();
      chk("b_val_consumed", 32'(b_out_val), 32'h0);
      chk("b_count_cleared", 32'(b_count), 32'd0);
      chk("b_data_stale", b_out_data, 32'h44332211);

      // Back-to-back: 8 beats streamed with IN_VAL and OUT_RDY held high
      c_out_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         c_in_val  = 1'b1;
         c_in_data = 8'(i + 1);
         #1;
         chk("c_b2b_rdy", 32'(c_in_rdy), 32'h1);
         tick();
         chk("c_b2b_count", 32'(c_count), 32'((i % 4) + 1));
         chk("c_b2b_val", 32'(c_out_val), 32'((i % 4) == 3));
         if (i == 3) chk("c_b2b_word0", c_out_data, 32'h01020304);
         if (i == 7) chk("c_b2b_word1", c_out_data, 32'h05060708);
      end
      c_in_val = 1'b0;
      tick();
      chk("c_b2b_drained_val", 32'(c_out_val), 32'h0);
      chk("c_b2b_drained_count", 32'(c_count), 32'd0);

      // Parallel load over a 2-beat partial word
      c_in_val = 1'b1; c_in_data = 8'hA1; tick();
      c_in_data = 8'hA2; tick();
      chk("c_partial_count", 32'(c_count), 32'd2);
      c_load_en = 1'b1; c_load_data = 32'hDEADBEEF; c_in_data = 8'hA3;
      #1;
      chk("c_load_rdy_low", 32'(c_in_rdy), 32'h0);
      tick();
      c_load_en = 1'b0; c_in_val = 1'b0; c_out_rdy = 1'b0;
      chk("c_load_val", 32'(c_out_val), 32'h1);
      chk("c_load_data", c_out_data, 32'hDEADBEEF);
      chk("c_load_count", 32'(c_count), 32'd4);
      tick();
      chk("c_load_hold", c_out_data, 32'hDEADBEEF);
      c_out_rdy = 1'b1;
      tick();
      chk("c_load_consumed", 32'(c_out_val), 32'h0);

      // Asynchronous reset between clock edges discards a partial word
      c_in_val = 1'b1; c_in_data = 8'h10; tick();
      c_in_data = 8'h20; tick();
      c_in_val = 1'b0;
      chk("c_pre_reset_count", 32'(c_count), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("c_async_rst_data", c_out_data, 32'h0);
      chk("c_async_rst_count", 32'(c_count), 32'd0);
      chk("c_async_rst_val", 32'(c_out_val), 32'h0);
      chk("a_async_rst_data", 32'(a_out_data), 32'h0);
      #1 rst_n = 1'b1;
      c_out_rdy = 1'b0;
      lane_beats[0] = 8'h0A; lane_beats[1] = 8'h0B; lane_beats[2] = 8'h0C; lane_beats[3] = 8'h0D;
      for (int i = 0; i < 4; i++) begin
         c_in_val  = 1'b1;
         c_in_data = lane_beats[i];
         tick();
      end
      c_in_val = 1'b0;
      chk("c_post_rst_val", 32'(c_out_val), 32'h1);
      chk("c_post_rst_data", c_out_data, 32'h0A0B0C0D);
      chk("c_post_rst_count", 32'(c_count), 32'd4);
      c_out_rdy = 1'b1;
      tick();
      chk("c_post_rst_consumed", 32'(c_out_val), 32'h0);

`ifdef SHIFTREG_DESER_FLUSH_EN
      // Flush of a 2-beat partial word, then flush with nothing pending
      c_in_val = 1'b1; c_in_data = 8'hAA; tick();
      c_in_data = 8'hBB; tick();
      c_in_val = 1'b0; c_out_rdy = 1'b0; c_flush = 1'b1;
      tick();
      c_flush = 1'b0;
      chk("c_flush_val", 32'(c_out_val), 32'h1);
      chk("c_flush_data", c_out_data, 32'hAABB0000);
      chk("c_flush_count", 32'(c_count), 32'd2);
      c_out_rdy = 1'b1;
      tick();
      chk("c_flush_consumed", 32'(c_out_val), 32'h0);
      c_flush = 1'b1;
      tick();
      c_flush = 1'b0;
      chk("c_flush_empty_val", 32'(c_out_val), 32'h0);
      chk("c_flush_empty_count", 32'(c_count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shiftreg_deser_valrdy.md
Name: shiftreg_deser_valrdy

Overview:
- Parametrised val/rdy deserializer built on a serial-in/parallel-out shift register.
- Accepts LANE_W-bit beats on an input val/rdy port and assembles BITWIDTH/LANE_W beats into one word.
- Presents the assembled word on an output val/rdy port; a parallel load path bypasses assembly.
- Sits between narrow serial links (SPI/bit-serial front ends) and word-wide val/rdy queues.

Parameters:
- BITWIDTH, 32, assembled word width; must be a multiple of LANE_W.
- LANE_W, 1, bits per input beat; BEATS = BITWIDTH/LANE_W, and BEATS must be at least 1.
- MSB_FIRST, 1: 1 = the first beat lands in the top lane (shift left); 0 = the first beat lands in the bottom lane (shift right).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VAL  in  1  input beat valid.
- IN_RDY  out  1  input beat ready.
- IN_DATA  in  LANE_W  input beat.
- LOAD_EN  in  1  parallel load strobe.
- LOAD_DATA  in  BITWIDTH  parallel load word.
- OUT_VAL  out  1  assembled word valid.
- OUT_RDY  in  1  downstream ready.
- OUT_DATA  out  BITWIDTH  assembled word (shift register contents).
- COUNT  out  clog2(BEATS+1)  beats accepted into the current word.

Behaviour:
- Reset (RESET_N low, asynchronous, takes effect regardless of CLK):
  - OUT_DATA=0, COUNT=0, state=FILL, OUT_VAL=0.
  - IN_RDY=1 once reset is deasserted.
  - Reset mid-word discards the partial word.
- States:
  - FILL (OUT_VAL=0, IN_RDY=~LOAD_EN).
  - FULL (OUT_VAL=1, IN_RDY=OUT_RDY & ~LOAD_EN).
- Input fire = IN_VAL & IN_RDY. Output fire = OUT_VAL & OUT_RDY.
- FILL, input fire:
  - Register shifts by LANE_W; IN_DATA enters the LSB lane when MSB_FIRST=1, the MSB lane otherwise.
  - COUNT increments.
  - On the beat that makes COUNT==BEATS: go to FULL next cycle, COUNT holds BEATS.
- FULL, no output fire: OUT_DATA, COUNT and state are held stable. Data never changes while OUT_VAL=1 and OUT_RDY=0.
- FULL, output fire, no input fire: go to FILL, COUNT=0. OUT_DATA keeps its stale contents until overwritten by shifting.
- FULL, output fire with simultaneous input fire:
  - The accepted beat becomes beat 0 of the next word and COUNT=1.
  - Next state is FILL, or FULL if BEATS==1.
  - This gives back-to-back throughput of one beat per cycle with no bubble.
- Latency: OUT_VAL rises the cycle after the last beat fires.
- LOAD_EN (highest priority, any state):
  - OUT_DATA=LOAD_DATA, COUNT=BEATS, state=FULL next cycle.
  - Any partial word is discarded.
  - IN_RDY=0 combinationally that cycle, so no beat is lost.
  - If an output fire coincides with LOAD_EN, the old word is consumed and the loaded word follows in the next cycle.
- Width rules:
  - COUNT never exceeds BEATS and never wraps.
  - A beat is written to exactly one lane.
  - No X propagation from an unused IN_DATA when IN_VAL=0.

Optional Feature:
- Macro: SHIFTREG_DESER_FLUSH_EN.
- Defined: adds input port FLUSH (1 bit).
  - When in FILL with COUNT>0, a FLUSH pulse forces state FULL next cycle; unfilled lanes are zero-padded.
    - MSB_FIRST=1: the register shifts by (BEATS-COUNT)*LANE_W with zeros in, so beat 0 ends up in the top lane.
    - MSB_FIRST=0: zeros are shifted in from the top, so beat 0 ends up in the bottom lane.
  - COUNT holds the partial count while FULL.
  - FLUSH is ignored if COUNT==0, if already FULL, or in the same cycle as LOAD_EN.
  - An input fire in the same cycle as FLUSH is included before padding.
- Undefined: no FLUSH port; a partial word waits indefinitely for its remaining beats.

Decomposition:
- Package shiftreg_pkg:
  - state enum {FILL, FULL}.
  - clog2-based COUNT width function.
  - BEATS derivation helper.
  - Elaboration-time check that BITWIDTH % LANE_W == 0.
- Sub-module shiftreg_lane_core:
  - BITWIDTH/LANE_W/MSB_FIRST-parametrised SIPO.
  - Async active-low reset, LOAD_EN and SHIFT_EN, with variable zero-pad shift when the flush macro is on.
- The top level holds the counter, FSM and handshake logic.

Test Plan:
- BITWIDTH=8, LANE_W=1, MSB_FIRST=1; send bits 1,0,1,1,0,0,1,0 with OUT_RDY=1 → OUT_VAL rises one cycle after the 8th beat, OUT_DATA=8'hB2, COUNT=8.
- BITWIDTH=32, LANE_W=8, MSB_FIRST=0; beats 0x11,0x22,0x33,0x44 with OUT_RDY held 0 for 5 cycles → OUT_DATA=32'h44332211 stable throughout, IN_RDY=0 while FULL; OUT_RDY=1 consumes the word.
- Back-to-back: stream 8 beats of LANE_W=8 into BITWIDTH=32 with IN_VAL and OUT_RDY held 1 → IN_RDY never drops, two words output with no bubble cycle.
- LOAD_EN with LOAD_DATA=32'hDEADBEEF after 2 partial beats → partial discarded, next cycle OUT_VAL=1, OUT_DATA=32'hDEADBEEF; IN_RDY=0 in the load cycle.
- RESET_N pulsed low mid-word, asynchronously between clock edges → OUT_DATA=0, COUNT=0, OUT_VAL=0 immediately; the next 4 beats assemble a clean word.
- With SHIFTREG_DESER_FLUSH_EN: BITWIDTH=32, LANE_W=8, MSB_FIRST=1; beats 0xAA,0xBB then FLUSH → OUT_DATA=32'hAABB0000, COUNT=2, OUT_VAL=1.
